// File: rtl/pulse_channel_sweep.sv
// pulse_channel_sweep: square-wave tone voice with frequency sweep, length counter
// and volume envelope, driven by frame-sequencer tick enables.
module pulse_channel_sweep #(
   parameter int FREQ_W = 11,
   parameter int LEN_W  = 6,
   parameter int VOL_W  = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              tick_256,
   input  logic              tick_128,
   input  logic              tick_64,
   input  logic [FREQ_W-1:0] freq,
   input  logic [LEN_W-1:0]  length_load,
   input  logic              length_load_wr,
   input  logic [1:0]        duty_cycle,
   input  logic [VOL_W-1:0]  starting_volume,
   input  logic [2:0]        env_period,
   input  logic              env_add,
   input  logic [2:0]        sweep_period,
   input  logic              sweep_negate,
   input  logic [2:0]        sweep_shift,
   input  logic              length_enable,
   input  logic              trigger,
   output logic [VOL_W-1:0]  amplitude,
   output logic              active,
   output logic [FREQ_W-1:0] freq_out
);
   localparam logic [LEN_W:0] LEN_MAX = {1'b1, {LEN_W{1'b0}}};

   logic [FREQ_W+1:0] timer;
   logic [2:0]        step;
   logic [2:0]        env_timer;
   logic [FREQ_W-1:0] shadow;
   logic [VOL_W-1:0]  volume;
   logic [3:0]        sweep_timer;
   logic [3:0]        sweep_reload;
   logic              sweep_en;
   logic [LEN_W:0]    len_cnt;
   logic [FREQ_W:0]   trig_new;
   logic [FREQ_W:0]   step_new;
   logic              trig_ovf;
   logic              step_ovf;
   logic              dac_on;
   logic [7:0]        pattern;

   function automatic logic [FREQ_W:0] sweep_calc(input logic [FREQ_W-1:0] s, input logic [2:0] sh,
                                                  input logic neg);
      logic [FREQ_W:0] d;
      d = {1'b0, s >> sh};
      return neg ? {1'b0, s} - d : {1'b0, s} + d;
   endfunction

   assign trig_new     = sweep_calc(freq, sweep_shift, sweep_negate);
   assign step_new     = sweep_calc(shadow, sweep_shift, sweep_negate);
   assign trig_ovf     = !sweep_negate && trig_new[FREQ_W];
   assign step_ovf     = !sweep_negate && step_new[FREQ_W];
   assign dac_on       = (starting_volume != '0) || env_add;
   assign sweep_reload = (sweep_period == 3'd0) ? 4'd8 : {1'b0, sweep_period};
   assign pattern      = (duty_cycle == 2'd0) ? 8'b1000_0000 :
                         (duty_cycle == 2'd1) ? 8'b1000_0001 :
                         (duty_cycle == 2'd2) ? 8'b1110_0001 : 8'b0111_1110;
   assign amplitude    = (active && pattern[step]) ? volume : '0;
   assign freq_out     = shadow;

   // Reload value ((2^FREQ_W - s) << 2) - 1 is simply {~s, 2'b11}.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         timer       <= '0;
         step        <= '0;
         env_timer   <= '0;
         shadow      <= '0;
         volume      <= '0;
         sweep_timer <= '0;
         sweep_en    <= 1'b0;
         len_cnt     <= '0;
         active      <= 1'b0;
      end else begin
         if (length_load_wr)
            len_cnt <= LEN_MAX - {1'b0, length_load};
         if (trigger && !dac_on) begin
            active <= 1'b0;
         end else if (trigger) begin
            active      <= !((sweep_shift != 3'd0) && trig_ovf);
            step        <= '0;
            timer       <= {~freq, 2'b11};
            shadow      <= freq;
            volume      <= starting_volume;
            env_timer   <= env_period;
            sweep_timer <= sweep_reload;
            sweep_en    <= (sweep_period != 3'd0) || (sweep_shift != 3'd0);
            if (!length_load_wr && len_cnt == '0)
               len_cnt <= LEN_MAX;
         end else begin
            if (active) begin
               if (timer == '0) begin
                  timer <= {~shadow, 2'b11};
                  step  <= step + 3'd1;
               end else
                  timer <= timer - 1'b1;
            end
            if (tick_256 && length_enable && !length_load_wr && len_cnt != '0) begin
               len_cnt <= len_cnt - 1'b1;
               if (len_cnt == {{LEN_W{1'b0}}, 1'b1})
                  active <= 1'b0;
            end
            if (tick_128 && active) begin
               if (sweep_timer <= 4'd1) begin
                  sweep_timer <= sweep_reload;
                  if (sweep_en && sweep_period != 3'd0) begin
                     if (step_ovf)
                        active <= 1'b0;
                     else if (sweep_shift != 3'd0)
                        shadow <= step_new[FREQ_W-1:0];
                  end
               end else
                  sweep_timer <= sweep_timer - 4'd1;
            end
            if (tick_64 && active && env_period != 3'd0) begin
               if (env_timer <= 3'd1) begin
                  env_timer <= env_period;
                  if (env_add && volume != {VOL_W{1'b1}})
                     volume <= volume + 1'b1;
                  else if (!env_add && volume != '0)
                     volume <= volume - 1'b1;
               end else
                  env_timer <= env_timer - 3'd1;
            end
         end
      end
   end
endmodule

// File: doc/pulse_channel_sweep.md
# pulse_channel_sweep

Parametrised square-wave channel with frequency sweep, length counter and volume envelope, one per tone voice in the sound core. It extends the fixed-width pulse channel with three additions: a sweep unit, configurable field widths, and a `active` status output. It runs on the single system clock. Frame-sequencer ticks arrive as one-cycle enables. Its `amplitude` feeds the mixer.

## Interface
- FREQ_W, 11: frequency field width.
- LEN_W, 6: length field width; the length counter is LEN_W+1 bits.
- VOL_W, 4: volume/amplitude width.
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- tick_256 / tick_128 / tick_64  in  1 each  one-cycle enables from the frame sequencer.
- freq  in  FREQ_W  frequency register; sampled into the shadow on trigger.
- length_load  in  LEN_W  length value.
- length_load_wr  in  1  strobe: length counter <= 2^LEN_W - length_load.
- duty_cycle  in  2  duty select.
- starting_volume  in  VOL_W  initial envelope volume.
- env_period  in  3  envelope step period in tick_64 units; 0 = frozen.
- env_add  in  1  1 = increase, 0 = decrease.
- sweep_period  in  3  sweep period in tick_128 units; 0 = no sweep steps.
- sweep_negate  in  1  1 = subtract, 0 = add.
- sweep_shift  in  3  sweep shift amount.
- length_enable  in  1  length counting enabled.
- trigger  in  1  one-cycle restart strobe.
- amplitude  out  VOL_W  current output sample.
- active  out  1  channel enabled.
- freq_out  out  FREQ_W  current shadow frequency.

## Operation
- **Reset values:** all registers 0; amplitude=0, active=0, freq_out=0.
- **Frequency timer:** FREQ_W+2 bit down-counter.
  - Reload value: ((2^FREQ_W - shadow) << 2) - 1.
  - Decrements every clk while active.
  - At 0: reloads and advances the 3-bit duty step, wrapping 7->0.
  - shadow=0 gives the maximum period, 2^(FREQ_W+2) cycles.
- **Duty patterns (bit high at listed steps):**
  - 00: step 7.
  - 01: steps 0, 7.
  - 10: steps 0, 5, 6, 7.
  - 11: steps 1–6.
- **Output:** amplitude = (active && pattern bit) ? volume : 0. Combinational from registered state.
- **Trigger:**
  - If starting_volume==0 and env_add==0 (DAC off): active stays 0 and nothing else changes.
  - Otherwise, with a single evaluation order:
    - active<=1.
    - duty step<=0; timer reloads from freq.
    - shadow<=freq.
    - volume<=starting_volume; env_timer<=env_period.
    - sweep_timer<=(sweep_period==0 ? 8 : sweep_period).
    - sweep_en<=(sweep_period!=0 || sweep_shift!=0).
    - If the length counter is 0, it loads 2^LEN_W.
    - If sweep_shift!=0: compute an immediate overflow check on freq; overflow forces active=0.
- **Sweep calculation:** new = shadow ± (shadow >> sweep_shift), computed at FREQ_W+1 bits.
  - Overflow = new > 2^FREQ_W - 1, add mode only.
  - Negate mode never overflows.
- **Sweep step (tick_128, while active):**
  - sweep_timer decrements.
  - At 0, it reloads as on trigger.
  - If sweep_en and sweep_period!=0:
    - overflow -> active<=0;
    - else if sweep_shift!=0 -> shadow<=new.
  - The new shadow takes effect at the next frequency-timer reload.
- **Length (tick_256):** if length_enable and counter!=0, decrement. Reaching 0 sets active<=0.
- **Envelope (tick_64, while active):** if env_period!=0, env_timer decrements. At 0 it reloads env_period and volume steps ±1, saturating at 2^VOL_W-1 and 0.

## Timing
- Trigger in cycle N -> active=1 and step 0 visible in cycle N+1. The first step advance occurs after the full reload period.
- Clearing of active (length, overflow) is visible the cycle after the causing tick; amplitude is 0 from that cycle.
- Simultaneous events:
  - trigger and any tick in the same cycle: trigger wins; that tick is ignored.
  - length_load_wr and trigger in the same cycle: the load is applied first; trigger's zero-check sees the loaded value (≥1), so there is no 2^LEN_W reload.
  - length_load_wr while active: counter is overwritten; active is unchanged.
- Register inputs other than trigger/length_load_wr may change anytime. duty_cycle and env_add act immediately; freq acts only on trigger.
- Reset mid-operation: all state returns to reset values asynchronously; the next trigger behaves as after power-up.

## Test plan
- **Duty/frequency:** defaults, freq=2047, duty=10, vol=15, trigger.
  - Required: 4-cycle steps; amplitude=15 on steps 0, 5, 6, 7, else 0; 32-cycle waveform.
- **Length:** length_load=62 with strobe, length_enable=1, trigger, two tick_256.
  - Required: active falls after the second tick; amplitude=0 thereafter.
- **Sweep overflow on trigger:** freq=1500, shift=1, negate=0.
  - Required: active=0 at N+1 (1500+750=2250 > 2047).
- **Sweep steps:** freq=1024, shift=2, negate=1, period=1; three tick_128.
  - Required: freq_out 1024 -> 768 -> 576 -> 432.
- **Envelope:** start=15, env_add=0, env_period=1; 16 tick_64.
  - Required: volume 15 -> 0 at the 15th tick, stays 0; with start=0/env_add=0, trigger leaves active=0.
- **Reset mid-play:** reset asserted mid-waveform.
  - Required: amplitude, active, freq_out=0 immediately, without waiting for a clk edge.
